// File: rtl/reg_write_arbiter_pkg.sv
// reg_write_arbiter_pkg: write-port special-register codes and arbiter FSM state encodings.
package reg_write_arbiter_pkg;
   localparam logic [1:0] SPEC_GEN = 2'b00;
   localparam logic [1:0] SPEC_SP  = 2'b01;
   localparam logic [1:0] SPEC_IH  = 2'b10;
   localparam logic [1:0] SPEC_T   = 2'b11;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_DBG_WR = 2'd2;
endpackage

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: shares the register-file write port between writeback and a debug/loader
// requester; writeback wins unless the debug write has lost MAX_WAIT cycles in a row.
module reg_write_arbiter
   import reg_write_arbiter_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        wbRegWrite,
   input  logic [1:0]  wbWriteSpecReg,
   input  logic [2:0]  wbR3,
   input  logic [15:0] wbData,
   input  logic        dbgReq,
   input  logic [1:0]  dbgSpecReg,
   input  logic [2:0]  dbgR3,
   input  logic [15:0] dbgData,
   output logic        dbgAck,
   output logic        wbStall,
   output logic        regWrite,
   output logic [1:0]  writeSpecReg,
   output logic [2:0]  R3,
   output logic [15:0] inData3
);
   logic [1:0]  state_q, state_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic        reg_write_q, dbg_ack_q;
   logic [1:0]  spec_q;
   logic [2:0]  r3_q;
   logic [15:0] data_q;
   logic        sel_dbg, sel_wb, stall;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      sel_dbg    = 1'b0;
      stall      = 1'b0;
      unique case (state_q)
         ST_IDLE:
            if (dbgReq && wbRegWrite) begin
               wait_cnt_d = 4'd1;
               state_d    = ST_WAIT;
            end else if (dbgReq) begin
               sel_dbg = 1'b1;
               state_d = ST_DBG_WR;
            end
         ST_WAIT:
            if (!dbgReq) begin
               wait_cnt_d = 4'd0;
               state_d    = ST_IDLE;
            end else if (!wbRegWrite) begin
               sel_dbg = 1'b1;
               state_d = ST_DBG_WR;
            end else if (wait_cnt_q < 4'(MAX_WAIT)) begin
               wait_cnt_d = wait_cnt_q + 4'd1;
            end else begin
               stall   = 1'b1;
               sel_dbg = 1'b1;
               state_d = ST_DBG_WR;
            end
         default: begin
            wait_cnt_d = 4'd0;
            state_d    = ST_IDLE;
         end
      endcase
      sel_wb = wbRegWrite && !sel_dbg;
   end

   // Unselected cycles leave the address/data registers untouched; only regWrite drops.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         wait_cnt_q  <= 4'd0;
         reg_write_q <= 1'b0;
         dbg_ack_q   <= 1'b0;
         spec_q      <= SPEC_GEN;
         r3_q        <= 3'd0;
         data_q      <= 16'h0000;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         reg_write_q <= sel_dbg || sel_wb;
         dbg_ack_q   <= sel_dbg;
         if (sel_dbg) begin
            spec_q <= dbgSpecReg;
            r3_q   <= dbgR3;
            data_q <= dbgData;
         end else if (sel_wb) begin
            spec_q <= wbWriteSpecReg;
            r3_q   <= wbR3;
            data_q <= wbData;
         end
      end
   end

   assign wbStall      = stall && !RST;
   assign dbgAck       = dbg_ack_q;
   assign regWrite     = reg_write_q;
   assign writeSpecReg = spec_q;
   assign R3           = r3_q;
   assign inData3      = data_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: scenario tasks feeding a queue of expected port writes, popped as the
// arbiter drives regWrite.
module tb_reg_write_arbiter;
   import reg_write_arbiter_pkg::*;

   typedef struct packed {
      logic [1:0]  sp;
      logic [2:0]  r3;
      logic [15:0] d;
      logic        ack;
   } wr_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        wbRegWrite = 1'b0;
   logic [1:0]  wbWriteSpecReg = 2'b00;
   logic [2:0]  wbR3 = 3'd0;
   logic [15:0] wbData = 16'h0;
   logic        dbgReq = 1'b0;
   logic [1:0]  dbgSpecReg = 2'b00;
   logic [2:0]  dbgR3 = 3'd0;
   logic [15:0] dbgData = 16'h0;
   logic        dbgAck, wbStall, regWrite;
   logic [1:0]  writeSpecReg;
   logic [2:0]  R3;
   logic [15:0] inData3;

   wr_t sb[$];
   wr_t e;
   int  n_chk = 0;
   int  n_fail = 0;

   reg_write_arbiter #(.MAX_WAIT(4)) dut (
      .CLK(CLK), .RST(RST),
      .wbRegWrite(wbRegWrite), .wbWriteSpecReg(wbWriteSpecReg), .wbR3(wbR3), .wbData(wbData),
      .dbgReq(dbgReq), .dbgSpecReg(dbgSpecReg), .dbgR3(dbgR3), .dbgData(dbgData),
      .dbgAck(dbgAck), .wbStall(wbStall), .regWrite(regWrite),
      .writeSpecReg(writeSpecReg), .R3(R3), .inData3(inData3)
   );

   always #5 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset;
      for (int c = 0; c < 2; c++) begin
         wbRegWrite = 1'($urandom); wbWriteSpecReg = 2'($urandom); wbR3 = 3'($urandom); wbData = 16'($urandom);
         dbgReq = 1'($urandom); dbgSpecReg = 2'($urandom); dbgR3 = 3'($urandom); dbgData = 16'($urandom);
         #1;
         n_chk++;
         if (wbStall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b required 0", wbStall); end
         tick();
         n_chk++;
         if ({regWrite, writeSpecReg, R3, inData3, dbgAck} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rw=%b sp=%b r3=%0d d=%h ack=%b required all 0", regWrite, writeSpecReg, R3, inData3, dbgAck);
         end
      end
      RST = 1'b0; wbRegWrite = 1'b0; dbgReq = 1'b0;
      tick();
   endtask

   task automatic test_idle_debug;
      dbgReq = 1'b1; dbgSpecReg = SPEC_GEN; dbgR3 = 3'd5; dbgData = 16'h1234; wbRegWrite = 1'b0;
      sb.push_back(wr_t'{SPEC_GEN, 3'd5, 16'h1234, 1'b1});
      for (int c = 0; c < 4; c++) begin
         #1;
         n_chk++;
         if (wbStall !== 1'b0) begin n_fail++; $display("FAIL idle_dbg_stall c%0d: got %b required 0", c, wbStall); end
         tick();
         n_chk++;
         if (regWrite !== 1'b1) begin
            if (dbgAck !== 1'b0) begin n_fail++; $display("FAIL idle_dbg_ack c%0d: got ack without write", c); end
         end else if (sb.size() == 0) begin
            n_fail++; $display("FAIL idle_dbg_extra c%0d: got write r3=%0d d=%h required none", c, R3, inData3);
         end else begin
            e = sb.pop_front();
            if ({writeSpecReg, R3, inData3, dbgAck} !== e) begin n_fail++; $display("FAIL idle_dbg_write c%0d: got %h required %h", c, {writeSpecReg, R3, inData3, dbgAck}, e); end
         end
         if (dbgAck) dbgReq = 1'b0;
      end
      n_chk++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL idle_dbg_missing: got %0d pending required 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_priority;
      wbRegWrite = 1'b1; wbWriteSpecReg = SPEC_GEN; wbR3 = 3'd2; wbData = 16'hAAAA;
      dbgReq = 1'b1; dbgSpecReg = SPEC_SP; dbgR3 = 3'd0; dbgData = 16'h5555;
      sb.push_back(wr_t'{SPEC_GEN, 3'd2, 16'hAAAA, 1'b0});
      for (int c = 0; c < 4; c++) begin
         if (c == 1) begin wbRegWrite = 1'b0; sb.push_back(wr_t'{SPEC_SP, 3'd0, 16'h5555, 1'b1}); end
         if (c == 2) begin
            wbRegWrite = 1'b1; wbWriteSpecReg = SPEC_T; wbR3 = 3'd1; wbData = 16'h7777;
            sb.push_back(wr_t'{SPEC_T, 3'd1, 16'h7777, 1'b0});
         end
         if (c == 3) wbRegWrite = 1'b0;
         #1;
         n_chk++;
         if (wbStall !== 1'b0) begin n_fail++; $display("FAIL prio_stall c%0d: got %b required 0", c, wbStall); end
         tick();
         n_chk++;
         if (regWrite !== 1'b1) begin
            if (dbgAck !== 1'b0) begin n_fail++; $display("FAIL prio_ack c%0d: got ack without write", c); end
         end else if (sb.size() == 0) begin
            n_fail++; $display("FAIL prio_extra c%0d: got write r3=%0d d=%h required none", c, R3, inData3);
         end else begin
            e = sb.pop_front();
            if ({writeSpecReg, R3, inData3, dbgAck} !== e) begin n_fail++; $display("FAIL prio_write c%0d: got %h required %h", c, {writeSpecReg, R3, inData3, dbgAck}, e); end
         end
         if (dbgAck) dbgReq = 1'b0;
      end
      n_chk++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL prio_missing: got %0d pending required 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_starvation;
      int  idx = 0;
      int  stalls = 0;
      logic exp_st;
      wbRegWrite = 1'b1; wbWriteSpecReg = SPEC_GEN;
      dbgReq = 1'b1; dbgSpecReg = SPEC_IH; dbgR3 = 3'd7; dbgData = 16'hBEEF;
      for (int c = 0; c < 7; c++) begin
         if (c == 6) wbRegWrite = 1'b0;
         wbR3 = 3'(idx); wbData = 16'h1000 + 16'(idx);
         exp_st = (c == 4);
         if (exp_st) sb.push_back(wr_t'{SPEC_IH, 3'd7, 16'hBEEF, 1'b1});
         else if (wbRegWrite) sb.push_back(wr_t'{SPEC_GEN, 3'(idx), 16'h1000 + 16'(idx), 1'b0});
         #1;
         n_chk++;
         if (wbStall !== exp_st) begin n_fail++; $display("FAIL starve_stall c%0d: got %b required %b", c, wbStall, exp_st); end
         if (wbStall === 1'b1) stalls++;
         tick();
         n_chk++;
         if (regWrite !== 1'b1) begin
            if (dbgAck !== 1'b0) begin n_fail++; $display("FAIL starve_ack c%0d: got ack without write", c); end
         end else if (sb.size() == 0) begin
            n_fail++; $display("FAIL starve_extra c%0d: got write r3=%0d d=%h required none", c, R3, inData3);
         end else begin
            e = sb.pop_front();
            if ({writeSpecReg, R3, inData3, dbgAck} !== e) begin n_fail++; $display("FAIL starve_write c%0d: got %h required %h", c, {writeSpecReg, R3, inData3, dbgAck}, e); end
         end
         if (dbgAck) dbgReq = 1'b0;
         if (!exp_st) idx++;
      end
      n_chk++;
      if (stalls != 1) begin n_fail++; $display("FAIL starve_stall_count: got %0d required 1", stalls); end
      n_chk++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL starve_missing: got %0d pending required 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_abort;
      wbWriteSpecReg = SPEC_GEN;
      for (int c = 0; c < 6; c++) begin
         case (c)
            0: begin wbRegWrite = 1'b1; wbR3 = 3'd3; wbData = 16'h0101; dbgReq = 1'b1; dbgSpecReg = SPEC_SP; dbgR3 = 3'd0; dbgData = 16'h9999;
                     sb.push_back(wr_t'{SPEC_GEN, 3'd3, 16'h0101, 1'b0}); end
            1: begin wbR3 = 3'd4; wbData = 16'h0202; dbgReq = 1'b0; sb.push_back(wr_t'{SPEC_GEN, 3'd4, 16'h0202, 1'b0}); end
            2: wbRegWrite = 1'b0;
            3: begin dbgReq = 1'b1; dbgSpecReg = SPEC_T; dbgR3 = 3'd6; dbgData = 16'h0C0C; sb.push_back(wr_t'{SPEC_T, 3'd6, 16'h0C0C, 1'b1}); end
            default: ;
         endcase
         #1;
         n_chk++;
         if (wbStall !== 1'b0) begin n_fail++; $display("FAIL abort_stall c%0d: got %b required 0", c, wbStall); end
         tick();
         n_chk++;
         if (regWrite !== 1'b1) begin
            if (dbgAck !== 1'b0) begin n_fail++; $display("FAIL abort_ack c%0d: got ack without write", c); end
         end else if (sb.size() == 0) begin
            n_fail++; $display("FAIL abort_extra c%0d: got write r3=%0d d=%h required none", c, R3, inData3);
         end else begin
            e = sb.pop_front();
            if ({writeSpecReg, R3, inData3, dbgAck} !== e) begin n_fail++; $display("FAIL abort_write c%0d: got %h required %h", c, {writeSpecReg, R3, inData3, dbgAck}, e); end
         end
         if (dbgAck) dbgReq = 1'b0;
      end
      n_chk++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL abort_missing: got %0d pending required 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_reset_mid_wait;
      wbRegWrite = 1'b1; wbWriteSpecReg = SPEC_GEN;
      dbgReq = 1'b1; dbgSpecReg = SPEC_GEN; dbgR3 = 3'd1; dbgData = 16'h3333;
      for (int c = 0; c < 7; c++) begin
         if (c < 3) begin wbR3 = 3'(c); wbData = 16'h2000 + 16'(c); sb.push_back(wr_t'{SPEC_GEN, 3'(c), 16'h2000 + 16'(c), 1'b0}); end
         if (c == 3) RST = 1'b1;
         if (c == 4) begin RST = 1'b0; wbRegWrite = 1'b0; sb.push_back(wr_t'{SPEC_GEN, 3'd1, 16'h3333, 1'b1}); end
         #1;
         n_chk++;
         if (wbStall !== 1'b0) begin n_fail++; $display("FAIL rstwait_stall c%0d: got %b required 0", c, wbStall); end
         tick();
         n_chk++;
         if (c == 3) begin
            if ({regWrite, writeSpecReg, R3, inData3, dbgAck} !== 23'd0) begin
               n_fail++; $display("FAIL rstwait_reset: got rw=%b d=%h ack=%b required all 0", regWrite, inData3, dbgAck);
            end
         end else if (regWrite !== 1'b1) begin
            if (dbgAck !== 1'b0) begin n_fail++; $display("FAIL rstwait_ack c%0d: got ack without write", c); end
         end else if (sb.size() == 0) begin
            n_fail++; $display("FAIL rstwait_extra c%0d: got write r3=%0d d=%h required none", c, R3, inData3);
         end else begin
            e = sb.pop_front();
            if ({writeSpecReg, R3, inData3, dbgAck} !== e) begin n_fail++; $display("FAIL rstwait_write c%0d: got %h required %h", c, {writeSpecReg, R3, inData3, dbgAck}, e); end
         end
         if (dbgAck) dbgReq = 1'b0;
      end
      n_chk++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL rstwait_missing: got %0d pending required 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_back_to_back;
      wbRegWrite = 1'b0;
      for (int c = 0; c < 5; c++) begin
         case (c)
            0: begin dbgReq = 1'b1; dbgSpecReg = SPEC_GEN; dbgR3 = 3'd2; dbgData = 16'h4444; sb.push_back(wr_t'{SPEC_GEN, 3'd2, 16'h4444, 1'b1}); end
            2: begin dbgSpecReg = SPEC_SP; dbgR3 = 3'd3; dbgData = 16'h5A5A; sb.push_back(wr_t'{SPEC_SP, 3'd3, 16'h5A5A, 1'b1}); end
            3: dbgReq = 1'b0;
            default: ;
         endcase
         #1;
         n_chk++;
         if (wbStall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall c%0d: got %b required 0", c, wbStall); end
         tick();
         n_chk++;
         if (regWrite !== 1'b1) begin
            if (dbgAck !== 1'b0) begin n_fail++; $display("FAIL b2b_ack c%0d: got ack without write", c); end
         end else if (sb.size() == 0) begin
            n_fail++; $display("FAIL b2b_extra c%0d: got write r3=%0d d=%h required none", c, R3, inData3);
         end else begin
            e = sb.pop_front();
            if ({writeSpecReg, R3, inData3, dbgAck} !== e) begin n_fail++; $display("FAIL b2b_write c%0d: got %h required %h", c, {writeSpecReg, R3, inData3, dbgAck}, e); end
         end
      end
      n_chk++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_missing: got %0d pending required 0", sb.size()); sb.delete(); end
   endtask

   initial begin
      test_reset();
      test_idle_debug();
      test_priority();
      test_starvation();
      test_abort();
      test_reset_mid_wait();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
